udc_bus_host: RTL
=================

// Module: udc_bus_host
// PURPOSE
//  Bus-side host for the up/down counter peripheral: drives its ncs/nwr/nrd/A1/A0/din bus.
//  On go: checks config, writes PLR/ULR/LLR/CCR, optionally reads them back, pulses start, waits for ec.
//  Reports one status code per run; sits between the control sequencer and the counter.
// PARAMETERS
//  STRB_CYC  2      cycles nwr/nrd held low per access (>=1)
//  VERIFY    1      1 = read back all four regs after writing; 0 = skip
//  TIMEOUT   65535  max cycles in WAIT_EC before timeout status
// PORTS
//  clk       in   1  single clock, all logic on posedge
//  rst       in   1  synchronous, active-high reset
//  go        in   1  start a run; sampled only in IDLE
//  plr_val   in   8  preload value    | ulr_val in 8 upper limit
//  llr_val   in   8  lower limit      | ccr_val in 8 cycle count
//  ncs       out  1  chip select, active low
//  nwr       out  1  write strobe, active low
//  nrd       out  1  read strobe, active low
//  A1, A0    out  1  register address
//  din       inout 8 bus data; driven only in write accesses, else 8'hzz
//  start     out  1  counter start, one-cycle pulse
//  ec        in   1  counter end-of-count
//  err       in   1  counter error flag
//  busy      out  1  high from accepted go until done
//  done      out  1  one-cycle pulse at run end
//  status    out  3  0 OK,1 BAD_CFG,2 VERIFY,3 CNT_ERR,4 TIMEOUT; held until next go
// BEHAVIOUR
//  Reset: ncs=nwr=nrd=1, A1=A0=0, din released, start=0, busy=0, done=0, status=0, FSM=IDLE.
//  Address map: write 00 PLR,01 ULR,10 LLR,11 CCR; read 00 PLR,01 LLR,10 ULR,11 CCR.
//  go in IDLE: latch the four values, busy=1. go while busy: ignored.
//  Precheck (cycle after go): llr>plr or plr>ulr or ccr==0 -> status=1, done, no bus activity.
//  Access = SETUP(1) + STRB(STRB_CYC) + HOLD(1) cycles:
//   SETUP: ncs=0, address valid, strobes high, write data driven.
//   STRB: nwr (write) or nrd (read) low; address and data stable.
//   HOLD: strobe high, ncs=0, write data still driven; then ncs=1 for 1 idle cycle.
//   Read data sampled from din at the edge ending the last STRB cycle.
//  Order: write PLR,ULR,LLR,CCR; if VERIFY read PLR,ULR,LLR,CCR via the read map.
//  Any readback mismatch: finish that read, status=2, done; no start.
//  Then START: start=1 for exactly one cycle, bus idle (ncs=1).
//  WAIT_EC: cycle counter from 0. ec=1 -> status=0; err=1 -> status=3; count==TIMEOUT -> status=4.
//  Same-cycle ec and err: err wins (status=3). err before start is ignored.
//  done: one-cycle pulse with busy falling the same cycle; status updates on the same edge.
//  FSM: IDLE->CHECK->{DONE|ACC(SETUP/STRB/HOLD/GAP)x4|x8}->START->WAIT_EC->DONE->IDLE.
//  din released (z) whenever not in a write SETUP/STRB/HOLD; never driven in read accesses.
//  rst mid-run: next edge returns all outputs to reset values, aborting any bus cycle.
// TESTING
//  go with plr=10,ulr=20,llr=5,ccr=2, model counter -> 4 writes then 4 reads; start pulse; ec -> done, status=0.
//  llr=30,plr=10,ulr=20 -> done 2 cycles after go, status=1, ncs never low.
//  Model corrupts LLR readback (drives 8'h06 on A1A0=01 read) -> status=2, start never pulses.
//  err asserted 3 cycles after start -> status=3; ec and err same cycle -> status=3.
//  TIMEOUT=16, ec never asserted -> done exactly 17 cycles after the start pulse, status=4.
//  rst during STRB of ULR write -> next cycle nwr=ncs=1, din z, busy=0; new go runs cleanly.

Source files
------------

// File: rtl/udc_bus_host.sv
// ---------------------------------------------------------------------------
// udc_bus_host
// Bus-side host for the up/down counter peripheral. Each run:
//   1. Latches the four configuration values and checks that they are sane.
//   2. Writes PLR, ULR, LLR and CCR over the ncs/nwr/nrd/A1/A0/din bus.
//   3. Optionally reads all four registers back and compares them.
//   4. Pulses start, then waits for ec, err or a timeout.
// One status code is reported per run, together with a one-cycle done pulse.
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   go                  start a run (sampled only while idle)
//   plr/ulr/llr/ccr_val preload, upper limit, lower limit, cycle count
//   ncs, nwr, nrd       active-low chip select, write strobe, read strobe
//   A1, A0              register address
//   din                 bidirectional data; driven only during write accesses
//   start               one-cycle counter start pulse
//   ec, err             counter end-of-count and error flags
//   busy                high from an accepted go until done
//   done                one-cycle end-of-run pulse
//   status              0 OK, 1 BAD_CFG, 2 VERIFY, 3 CNT_ERR, 4 TIMEOUT
// ---------------------------------------------------------------------------
module udc_bus_host #(
    parameter int STRB_CYC = 2,
    parameter bit VERIFY   = 1'b1,
    parameter int TIMEOUT  = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [7:0] plr_val,
    input  logic [7:0] ulr_val,
    input  logic [7:0] llr_val,
    input  logic [7:0] ccr_val,
    output logic       ncs,
    output logic       nwr,
    output logic       nrd,
    output logic       A1,
    output logic       A0,
    inout  wire  [7:0] din,
    output logic       start,
    input  logic       ec,
    input  logic       err,
    output logic       busy,
    output logic       done,
    output logic [2:0] status
);

    localparam int SW = (STRB_CYC > 1) ? $clog2(STRB_CYC) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // Accesses 0..3 are writes, 4..7 are read-backs.
    localparam logic [2:0] LAST_IDX = VERIFY ? 3'd7 : 3'd3;

    localparam logic [2:0] ST_OK      = 3'd0;
    localparam logic [2:0] ST_BAD_CFG = 3'd1;
    localparam logic [2:0] ST_VERIFY  = 3'd2;
    localparam logic [2:0] ST_CNT_ERR = 3'd3;
    localparam logic [2:0] ST_TIMEOUT = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_SETUP, S_STRB, S_HOLD, S_GAP, S_START, S_WAIT, S_DONE
    } state_t;

    state_t          state_reg;
    logic [7:0]      val_reg [4];     // 0 PLR, 1 ULR, 2 LLR, 3 CCR
    logic [2:0]      idx_reg;
    logic [SW-1:0]   strb_cnt_reg;
    logic [TW-1:0]   wait_cnt_reg;
    logic            match_reg;
    logic            drive_reg;
    logic [7:0]      dout_reg;
    logic [2:0]      acc_idx;
    logic [3:0]      rd_match;

    assign din = drive_reg ? dout_reg : 8'hzz;

    // One comparator per register; the current read selects its result.
    for (genvar gi = 0; gi < 4; gi++) begin : g_rd_cmp
        assign rd_match[gi] = (din == val_reg[gi]);
    end

    // Index of the access being launched: first one from CHECK, else the next.
    always_comb begin
        acc_idx = idx_reg + 3'd1;
        if (state_reg == S_CHECK) begin
            acc_idx = 3'd0;
        end
    end

    // Writes use the index directly; reads swap the address bits so that
    // ULR appears at 10 and LLR at 01.
    function automatic logic [1:0] acc_addr(input logic [2:0] idx);
        return idx[2] ? {idx[0], idx[1]} : idx[1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            for (int i = 0; i < 4; i++) begin
                val_reg[i] <= 8'h00;
            end
            idx_reg      <= 3'd0;
            strb_cnt_reg <= '0;
            wait_cnt_reg <= '0;
            match_reg    <= 1'b1;
            drive_reg    <= 1'b0;
            dout_reg     <= 8'h00;
            ncs          <= 1'b1;
            nwr          <= 1'b1;
            nrd          <= 1'b1;
            A1           <= 1'b0;
            A0           <= 1'b0;
            start        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            status       <= ST_OK;
        end else begin
            start <= 1'b0;
            done  <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (go) begin
                        val_reg[0] <= plr_val;
                        val_reg[1] <= ulr_val;
                        val_reg[2] <= llr_val;
                        val_reg[3] <= ccr_val;
                        busy       <= 1'b1;
                        state_reg  <= S_CHECK;
                    end
                end
                S_CHECK, S_GAP: begin
                    if (state_reg == S_CHECK &&
                        ((val_reg[2] > val_reg[0]) || (val_reg[0] > val_reg[1]) ||
                         (val_reg[3] == 8'h00))) begin
                        status    <= ST_BAD_CFG;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= S_DONE;
                    end else if (state_reg == S_GAP && idx_reg == LAST_IDX) begin
                        start     <= 1'b1;
                        state_reg <= S_START;
                    end else begin
                        ncs        <= 1'b0;
                        {A1, A0}   <= acc_addr(acc_idx);
                        drive_reg  <= ~acc_idx[2];
                        dout_reg   <= val_reg[acc_idx[1:0]];
                        idx_reg    <= acc_idx;
                        state_reg  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (idx_reg[2]) begin
                        nrd <= 1'b0;
                    end else begin
                        nwr <= 1'b0;
                    end
                    strb_cnt_reg <= '0;
                    state_reg    <= S_STRB;
                end
                S_STRB: begin
                    if (strb_cnt_reg == SW'(STRB_CYC - 1)) begin
                        nwr       <= 1'b1;
                        nrd       <= 1'b1;
                        // Read data is captured on the edge that ends the strobe.
                        if (idx_reg[2]) begin
                            match_reg <= rd_match[idx_reg[1:0]];
                        end
                        state_reg <= S_HOLD;
                    end else begin
                        strb_cnt_reg <= strb_cnt_reg + SW'(1);
                    end
                end
                S_HOLD: begin
                    ncs       <= 1'b1;
                    drive_reg <= 1'b0;
                    if (idx_reg[2] && !match_reg) begin
                        status    <= ST_VERIFY;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= S_DONE;
                    end else begin
                        state_reg <= S_GAP;
                    end
                end
                S_START: begin
                    wait_cnt_reg <= '0;
                    state_reg    <= S_WAIT;
                end
                S_WAIT: begin
                    // err has priority over a same-cycle ec.
                    if (err || ec || wait_cnt_reg == TW'(TIMEOUT - 1)) begin
                        status    <= err ? ST_CNT_ERR : (ec ? ST_OK : ST_TIMEOUT);
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= S_DONE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + TW'(1);
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule
